// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared encodings and small helpers for the multi-cycle
// multiply/divide unit in the Execute stage.
package mcycle_pkg;

    typedef enum logic [1:0] {
        MC_MUL  = 2'b00,
        MC_MULU = 2'b01,
        MC_DIV  = 2'b10,
        MC_DIVU = 2'b11
    } mc_op_e;

    typedef enum logic [1:0] {
        MC_IDLE      = 2'b00,
        MC_COMPUTING = 2'b01,
        MC_DONE      = 2'b10
    } mc_state_e;

    // Bit 0 of the op code selects unsigned handling.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Bit 1 of the op code selects divide.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mcycle_iter_datapath.sv
// mcycle_iter_datapath: shared shift registers and adder/subtractor for the
// iterative multiply (shift-add) and restoring divide. Operands arrive as
// magnitudes; sign handling lives in the top.
//   multiply: lo = multiplier (shifted out LSB first), b = multiplicand,
//             hi = upper accumulator; product = {hi, lo} after WIDTH steps.
//   divide:   lo = dividend (shifted out MSB first, quotient shifted in),
//             b = divisor, hi = partial remainder.
module mcycle_iter_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] load_lo,
    input  logic [WIDTH-1:0] load_b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             q_bit;
    logic [WIDTH:0]   div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;

    // One iteration of either algorithm, plus load/hold of the registers.
    // hi_q[WIDTH] stays zero in both modes (partial remainder < divisor).
    always_comb begin
        mul_addend = lo_q[0] ? b_q : '0;
        mul_sum    = hi_q + {1'b0, mul_addend};
        mul_hi     = {1'b0, mul_sum[WIDTH:1]};
        mul_lo     = {mul_sum[0], lo_q[WIDTH-1:1]};

        rem_sh     = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        trial      = {1'b0, rem_sh} - {2'b00, b_q};
        q_bit      = ~trial[WIDTH+1];
        div_hi     = q_bit ? trial[WIDTH:0] : rem_sh;
        div_lo     = {lo_q[WIDTH-2:0], q_bit};

        step_hi    = div_mode ? div_hi : mul_hi;
        step_lo    = div_mode ? div_lo : mul_lo;

        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;
        if (load) begin
            hi_d = '0;
            lo_d = load_lo;
            b_d  = load_b;
        end else if (step) begin
            hi_d = step_hi;
            lo_d = step_lo;
        end

        hi_next = step_hi[WIDTH-1:0];
        lo_next = step_lo;
    end

    // Iteration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative multiply/divide for the Execute stage. Busy stalls
// F/D and holds E/M; Done pulses for one cycle with Result1/Result2 valid.
// Optional build macro MCYCLE_FAST_MUL_EN: multiplies complete through a
// single registered '*' product (IDLE -> DONE); divides stay iterative.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// MC_IDLE      | waiting for Start; operands/op/sign flags latched on exit
// MC_COMPUTING | one multiplier/quotient bit per cycle, WIDTH cycles
// MC_DONE      | results valid, Done=1, Busy=0 even if Start is still high
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    mc_state_e        state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic [WIDTH-1:0] res2_q, res2_d;

    logic             start_accept;
    logic             in_div;
    logic             op1_neg, op2_neg;
    logic [WIDTH-1:0] op1_abs, op2_abs;
    logic [WIDTH-1:0] dp_load_lo, dp_load_b;
    logic [WIDTH-1:0] dp_hi_next, dp_lo_next;
    logic [2*WIDTH-1:0] product, product_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef MCYCLE_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
`endif

    // Operand sign split and routing into the shared datapath.
    always_comb begin
        in_div     = op_is_div(MCycleOp);
        op1_neg    = op_is_signed(MCycleOp) & Operand1[WIDTH-1];
        op2_neg    = op_is_signed(MCycleOp) & Operand2[WIDTH-1];
        op1_abs    = op1_neg ? -Operand1 : Operand1;
        op2_abs    = op2_neg ? -Operand2 : Operand2;
        dp_load_lo = in_div ? op1_abs : op2_abs;
        dp_load_b  = in_div ? op2_abs : op1_abs;
    end

    assign start_accept = (state_q == MC_IDLE) && Start;

    mcycle_iter_datapath #(
        .WIDTH    (WIDTH)
    ) u_datapath (
        .clk      (CLK),
        .rst      (RESET),
        .load     (start_accept),
        .step     (state_q == MC_COMPUTING),
        .div_mode (op_q[1]),
        .load_lo  (dp_load_lo),
        .load_b   (dp_load_b),
        .hi_next  (dp_hi_next),
        .lo_next  (dp_lo_next)
    );

    // Sign fix-up of the final iteration's outputs.
    always_comb begin
        product     = {dp_hi_next, dp_lo_next};
        product_fix = neg_lo_q ? -product : product;
        quo_fix     = neg_lo_q ? -dp_lo_next : dp_lo_next;
        rem_fix     = neg_hi_q ? -dp_hi_next : dp_hi_next;
    end

`ifdef MCYCLE_FAST_MUL_EN
    // Single-cycle product; truncating a 2*WIDTH multiply of sign-extended
    // operands yields the correct signed or unsigned product.
    always_comb begin
        fast_a    = op_is_signed(MCycleOp) ? {{WIDTH{Operand1[WIDTH-1]}}, Operand1}
                                           : {{WIDTH{1'b0}}, Operand1};
        fast_b    = op_is_signed(MCycleOp) ? {{WIDTH{Operand2[WIDTH-1]}}, Operand2}
                                           : {{WIDTH{1'b0}}, Operand2};
        fast_prod = fast_a * fast_b;
    end
`endif

    // Next-state, counter, latched-operand and result-register logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        div_zero_d = div_zero_q;
        dividend_d = dividend_q;
        res1_d     = res1_q;
        res2_d     = res2_q;

        case (state_q)
            MC_IDLE: begin
                if (Start) begin
                    op_d       = MCycleOp;
                    neg_lo_d   = op1_neg ^ op2_neg;
                    neg_hi_d   = op1_neg;
                    div_zero_d = (Operand2 == '0);
                    dividend_d = Operand1;
                    count_d    = '0;
                    state_d    = MC_COMPUTING;
`ifdef MCYCLE_FAST_MUL_EN
                    if (!in_div) begin
                        state_d = MC_DONE;
                        res1_d  = fast_prod[WIDTH-1:0];
                        res2_d  = fast_prod[2*WIDTH-1:WIDTH];
                    end
`endif
                end
            end
            MC_COMPUTING: begin
                count_d = count_q + CW'(1);
                if (count_q == LAST_COUNT) begin
                    state_d = MC_DONE;
                    count_d = '0;
                    case (op_q)
                        MC_MUL, MC_MULU: begin
                            res1_d = product_fix[WIDTH-1:0];
                            res2_d = product_fix[2*WIDTH-1:WIDTH];
                        end
                        default: begin
                            // Divide by zero overrides the sign fix-up.
                            if (div_zero_q) begin
                                res1_d = '1;
                                res2_d = dividend_q;
                            end else begin
                                res1_d = quo_fix;
                                res2_d = rem_fix;
                            end
                        end
                    endcase
                end
            end
            MC_DONE: begin
                state_d = MC_IDLE;
            end
            default: begin
                state_d = MC_IDLE;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= MC_IDLE;
            count_q    <= '0;
            op_q       <= MC_MUL;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            dividend_q <= '0;
            res1_q     <= '0;
            res2_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            div_zero_q <= div_zero_d;
            dividend_q <= dividend_d;
            res1_q     <= res1_d;
            res2_q     <= res2_d;
        end
    end

    // Busy must drop in DONE even with Start still high: same instruction in E.
    assign Busy    = start_accept || (state_q == MC_COMPUTING);
    assign Done    = (state_q == MC_DONE);
    assign Result1 = res1_q;
    assign Result2 = res2_q;

endmodule
